pdm_cic_decimator: RTL and testbench

// First decimation stage of the PDM microphone receive chain. Takes a 1-bit PDM

---
 rtl/pdm_cic_decimator.sv | 97 +++++++++
 tb/tb_pdm_cic_decimator.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pdm_cic_decimator.sv
// PDM-to-PCM first decimation stage: ORDER-stage Hogenauer CIC, decimate by RATE.
// Emits an unsigned sample with a one-clk valid strobe and a clk/RATE square wave.
module pdm_cic_decimator #(
    parameter  int ORDER = 4,
    parameter  int RATE  = 16,
    localparam int OUT_W = ORDER * $clog2(RATE) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_in,
    output logic [OUT_W-1:0] y_out,
    output logic             y_valid,
    output logic             clkdiv
);

    localparam int CNT_W = $clog2(RATE);

    logic [CNT_W-1:0] phase_reg;
    logic             strobe;
    logic             half_point;

    logic [OUT_W-1:0] integ_reg    [ORDER];
    logic [OUT_W-1:0] integ_next   [ORDER];
    logic [OUT_W-1:0] comb_dly_reg [ORDER];
    logic [OUT_W-1:0] comb_in      [ORDER];
    logic [OUT_W-1:0] comb_out;

    logic [OUT_W-1:0] y_out_reg;
    logic             y_valid_reg;
    logic             clkdiv_reg;

    assign strobe     = (phase_reg == CNT_W'(RATE - 1));
    assign half_point = (phase_reg == CNT_W'(RATE / 2 - 1));

    // Integrator chain: each stage accumulates the previous stage's registered value,
    // modulo 2^OUT_W; the final comb difference recovers the exact result.
    genvar gi;
    generate
        for (gi = 0; gi < ORDER; gi++) begin : g_integ
            if (gi == 0) begin : g_first
                assign integ_next[gi] = integ_reg[gi] + OUT_W'(x_in);
            end else begin : g_rest
                assign integ_next[gi] = integ_reg[gi] + integ_reg[gi-1];
            end
        end
    endgenerate

    // Comb chain evaluated combinationally within the strobe cycle (M=1).
    generate
        for (gi = 0; gi < ORDER; gi++) begin : g_comb
            logic [OUT_W-1:0] c_in;
            logic [OUT_W-1:0] c_out;
            if (gi == 0) begin : g_src
                assign c_in = integ_reg[ORDER-1];
            end else begin : g_link
                assign c_in = g_comb[gi-1].c_out;
            end
            assign c_out       = c_in - comb_dly_reg[gi];
            assign comb_in[gi] = c_in;
        end
    endgenerate

    assign comb_out = g_comb[ORDER-1].c_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg   <= '0;
            y_out_reg   <= '0;
            y_valid_reg <= 1'b0;
            clkdiv_reg  <= 1'b0;
            for (int k = 0; k < ORDER; k++) begin
                integ_reg[k]    <= '0;
                comb_dly_reg[k] <= '0;
            end
        end else begin
            phase_reg   <= phase_reg + CNT_W'(1);
            y_valid_reg <= strobe;
            for (int k = 0; k < ORDER; k++) begin
                integ_reg[k] <= integ_next[k];
            end
            if (strobe) begin
                y_out_reg <= comb_out;
                for (int k = 0; k < ORDER; k++) begin
                    comb_dly_reg[k] <= comb_in[k];
                end
            end
            if (strobe || half_point) begin
                clkdiv_reg <= ~clkdiv_reg;
            end
        end
    end

    assign y_out   = y_out_reg;
    assign y_valid = y_valid_reg;
    assign clkdiv  = clkdiv_reg;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Randomized bench for pdm_cic_decimator against a convolution-kernel model
// (boxcar^ORDER impulse response, decimated), plus fixed DC-pattern expectations.
module tb_pdm_cic_decimator;

    localparam int ORDER = 4;
    localparam int RATE  = 16;
    localparam int OUT_W = 17;
    localparam int KLEN  = ORDER * (RATE - 1) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             x_in = 1'b0;
    logic [OUT_W-1:0] y_out;
    logic             y_valid;
    logic             clkdiv;

    pdm_cic_decimator #(.ORDER(ORDER), .RATE(RATE)) dut (
        .clk    (clk),
        .rst    (rst),
        .x_in   (x_in),
        .y_out  (y_out),
        .y_valid(y_valid),
        .clkdiv (clkdiv)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    longint kernel [KLEN];
    int     hist   [$];
    int     cyc;
    int     n_samples;
    longint y_model;
    int     dc_expect;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp_v);
        end
    endtask

    // Impulse response of the whole filter: a length-RATE boxcar convolved ORDER times.
    task automatic build_kernel();
        longint tmp [KLEN];
        int len;
        for (int i = 0; i < KLEN; i++) kernel[i] = 0;
        kernel[0] = 1;
        len = 1;
        for (int s = 0; s < ORDER; s++) begin
            for (int i = 0; i < KLEN; i++) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int b = 0; b < RATE; b++) tmp[i+b] += kernel[i];
            len += RATE - 1;
            for (int i = 0; i < KLEN; i++) kernel[i] = tmp[i];
        end
    endtask

    function automatic longint conv_at(input int c);
        longint acc = 0;
        for (int j = 0; j < KLEN; j++) begin
            int idx = c - ORDER - j;
            if (idx >= 0 && idx < hist.size()) acc += kernel[j] * longint'(hist[idx]);
        end
        return acc;
    endfunction

    // One clock: drive inputs, advance model, check every output after the edge.
    task automatic step(input logic xb, input logic r);
        int  c_edge;
        logic exp_valid, exp_div;
        x_in = xb;
        rst  = r;
        @(posedge clk);
        #1;
        if (r) begin
            hist.delete();
            cyc = 0;
            n_samples = 0;
            y_model = 0;
            chk("rst_y_out", 32'(y_out), 32'd0);
            chk("rst_y_valid", 32'(y_valid), 32'd0);
            chk("rst_clkdiv", 32'(clkdiv), 32'd0);
        end else begin
            hist.push_back(int'(xb));
            c_edge = cyc;
            cyc++;
            exp_valid = ((c_edge % RATE) == RATE - 1);
            exp_div   = ((c_edge % RATE) >= RATE / 2 - 1) && ((c_edge % RATE) < RATE - 1);
            if (exp_valid) begin
                y_model = conv_at(c_edge);
                n_samples++;
            end
            chk("y_valid", 32'(y_valid), 32'(exp_valid));
            chk("clkdiv", 32'(clkdiv), 32'(exp_div));
            chk("y_out_model", 32'(y_out), 32'(y_model));
            if (exp_valid && dc_expect >= 0 && n_samples >= ORDER + 1)
                chk("y_out_dc", 32'(y_out), 32'(dc_expect));
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'b1);
    endtask

    initial begin
        cyc = 0;
        n_samples = 0;
        y_model = 0;
        dc_expect = -1;
        build_kernel();

        // Reset behaviour and random PDM against the model
        do_reset(3);
        for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 1)), 1'b0);

        // All-zero input
        do_reset(2);
        dc_expect = 0;
        for (int i = 0; i < 200; i++) step(1'b0, 1'b0);

        // All-ones input, long enough for many integrator wraps
        do_reset(2);
        dc_expect = 65536;
        for (int i = 0; i < 10000; i++) step(1'b1, 1'b0);

        // Alternating 1,0
        do_reset(2);
        dc_expect = 32768;
        for (int i = 0; i < 400; i++) step(1'(i % 2 == 0), 1'b0);

        // Repeating 1,0,0,0
        do_reset(2);
        dc_expect = 16384;
        for (int i = 0; i < 400; i++) step(1'(i % 4 == 0), 1'b0);

        // Mid-run reset pulse, then the step response must repeat
        do_reset(1);
        dc_expect = 65536;
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0);

        // Random density PDM, with reset pulses landing at random phases
        dc_expect = -1;
        for (int blk = 0; blk < 4; blk++) begin
            int dens = $urandom_range(0, 100);
            do_reset(1);
            for (int i = 0; i < 300 + $urandom_range(0, 40); i++)
                step(1'($urandom_range(0, 99) < dens), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
